bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Shares the single external Wishbone-style memory port between the instruction-fetch requester (IF) and the data-access requester (MEM stage: loads/stores computed from mem_addr_o/aluop_o).
- Sequences each bus cycle, returns read data, and raises per-side stall requests to the pipeline controller.
- Drops the fetch result on a pipeline flush.
- Terminates hung cycles with a timeout.

Parameters:
TIMEOUT_CYCLES, 255, bus cycles without ack before the transfer is aborted with bus_err_o (legal range 2..255).

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  reset; asynchronous, active-low (0 = reset)
if_req_i  in  1  IF requests a 32-bit instruction read
if_addr_i  in  32  fetch address (word aligned)
if_data_o  out  32  fetched instruction, valid while if_ready_o=1
if_ready_o  out  1  one-cycle completion pulse for IF
mem_req_i  in  1  MEM requests a data access
mem_we_i  in  1  1 = store, 0 = load
mem_sel_i  in  4  byte enables
mem_addr_i  in  32  data address
mem_data_i  in  32  store data
mem_data_o  out  32  load data, valid while mem_ready_o=1
mem_ready_o  out  1  one-cycle completion pulse for MEM
flush_i  in  1  pipeline flush (exception/eret)
stallreq_if_o  out  1  IF stall request
stallreq_mem_o  out  1  MEM stall request
bus_cyc_o  out  1  bus cycle active
bus_stb_o  out  1  strobe
bus_we_o  out  1  write enable
bus_sel_o  out  4  byte select
bus_addr_o  out  32  bus address
bus_data_o  out  32  bus write data
bus_data_i  in  32  bus read data
bus_ack_i  in  1  slave acknowledge
bus_err_o  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, timeout counter=0, annul flag=0.
  - All registered outputs 0; bus_sel_o=4'b0000.
- States: IDLE, BUSY_IF, BUSY_MEM.
- IDLE:
  - Samples requests. MEM has priority over IF (MEM belongs to the older instruction).
  - Grant is registered: request seen in cycle n drives bus_cyc_o=bus_stb_o=1 with address/we/sel/data in cycle n+1.
  - IF grant: we=0, sel=4'b1111.
- BUSY_x:
  - Bus outputs held stable until bus_ack_i=1 is sampled, at clock edge k.
  - At edge k: cyc/stb drop to 0 and x_ready_o=1 with x_data_o=bus_data_i (0 for stores), both for one cycle (cycle k+1). State returns to IDLE.
  - Minimum latency from request to ready: 2 cycles with zero-wait ack.
- Back-to-back: in the IDLE cycle that carries a ready pulse, a new grant is not issued. The requester deasserts/updates req in response to ready. Maximum throughput: one transfer per 3 cycles.
- Stall:
  - stallreq_if_o = if_req_i & ~if_ready_o.
  - stallreq_mem_o = mem_req_i & ~mem_ready_o.
  - Both are combinational from registered ready.
- Flush:
  - flush_i=1 in IDLE cancels any pending IF grant for that cycle.
  - flush_i=1 during BUSY_IF sets annul. The bus cycle runs to ack/timeout, but if_ready_o is suppressed; annul clears on return to IDLE.
  - MEM transfers are never annulled; stores already on the bus must complete.
- Timeout:
  - Counter increments each BUSY cycle without ack and clears on entry to BUSY.
  - On reaching TIMEOUT_CYCLES-1 with no ack: cyc/stb drop, bus_err_o=1 for one cycle, the owner's ready pulses with data 32'h0, state goes to IDLE.
  - Ack in the same cycle as the timeout wins: normal completion, no error.
- Ack while IDLE is ignored.
- Reset mid-transfer aborts immediately; cyc drops asynchronously.

Decomposition:
- Shared defines file gets:
  - state encodings (BusIdle, BusBusyIf, BusBusyMem);
  - BusSelAll=4'b1111;
  - timeout counter width (8).
- No sub-module; arbitration, FSM and timeout counter are one always-block group.

Test Plan:
- IF only: if_req_i=1, if_addr_i=32'h0000_0100, ack one cycle after stb, bus_data_i=32'h3C01_1234 -> bus_addr_o=32'h100, sel=4'hF, we=0; if_ready_o pulses with if_data_o=32'h3C01_1234; stallreq_if_o low that cycle.
- Simultaneous: if_req_i=1 and mem_req_i=1 (store, addr 32'h80, data 32'hDEAD_BEEF, sel 4'b0011) -> store issued first (we=1, sel=3); mem_ready_o pulses; fetch issued 1 cycle later; stallreq_if_o held high until if_ready_o.
- Flush: fetch in BUSY_IF, flush_i=1 for one cycle, ack 3 cycles later -> cyc stays 1 until ack, if_ready_o never pulses, next IF request is granted normally.
- Timeout: TIMEOUT_CYCLES=4, load with bus_ack_i held 0 -> cyc drops after 4 busy cycles; bus_err_o and mem_ready_o pulse together with mem_data_o=0.
- Ack on timeout cycle: ack arrives exactly at count 3 (TIMEOUT_CYCLES=4) -> normal completion with read data, bus_err_o stays 0.
- Async reset during BUSY_MEM: rst=0 asserted between edges -> bus_cyc_o/bus_stb_o fall immediately, all outputs 0, IDLE after release.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared encodings and constants for the instruction/data bus arbiter.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        BusIdle    = 2'd0,
        BusBusyIf  = 2'd1,
        BusBusyMem = 2'd2
    } bus_state_e;

    localparam logic [3:0] BusSelAll   = 4'b1111;
    localparam int         TimeoutCntW = 8;

endpackage

// File: rtl/bus_arbiter.sv
// Arbitrates one Wishbone-style memory port between instruction fetch and data access,
// with registered grant, flush annulment of fetches and a hung-cycle timeout.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_ready_o,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        mem_ready_o,
    input  logic        flush_i,
    output logic        stallreq_if_o,
    output logic        stallreq_mem_o,
    output logic        bus_cyc_o,
    output logic        bus_stb_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_data_o,
    input  logic [31:0] bus_data_i,
    input  logic        bus_ack_i,
    output logic        bus_err_o
);

    localparam logic [TimeoutCntW-1:0] TimeoutLast = TimeoutCntW'(TIMEOUT_CYCLES - 1);

    bus_state_e             state_q, state_d;
    logic [TimeoutCntW-1:0] cnt_q, cnt_d;
    logic                   annul_q, annul_d;
    logic                   cyc_q, cyc_d;
    logic                   we_q, we_d;
    logic [3:0]             sel_q, sel_d;
    logic [31:0]            addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic                   if_ready_q, if_ready_d;
    logic [31:0]            if_data_q, if_data_d;
    logic                   mem_ready_q, mem_ready_d;
    logic [31:0]            mem_data_q, mem_data_d;
    logic                   err_q, err_d;

    // NOTE: asynchronous reset so a reset mid-transfer drops cyc/stb without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= BusIdle;
            cnt_q       <= '0;
            annul_q     <= 1'b0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= 4'b0000;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_ready_q  <= 1'b0;
            if_data_q   <= '0;
            mem_ready_q <= 1'b0;
            mem_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            annul_q     <= annul_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_ready_q  <= if_ready_d;
            if_data_q   <= if_data_d;
            mem_ready_q <= mem_ready_d;
            mem_data_q  <= mem_data_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        annul_d     = annul_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_ready_d  = 1'b0;
        if_data_d   = '0;
        mem_ready_d = 1'b0;
        mem_data_d  = '0;
        err_d       = 1'b0;

        unique case (state_q)
            BusIdle: begin
                annul_d = 1'b0;
                // No new grant in the cycle carrying a ready pulse; the requester is still updating req.
                if (!(if_ready_q || mem_ready_q)) begin
                    if (mem_req_i) begin
                        state_d = BusBusyMem;
                        cnt_d   = '0;
                        cyc_d   = 1'b1;
                        we_d    = mem_we_i;
                        sel_d   = mem_sel_i;
                        addr_d  = mem_addr_i;
                        wdata_d = mem_data_i;
                    end else if (if_req_i && !flush_i) begin
                        state_d = BusBusyIf;
                        cnt_d   = '0;
                        cyc_d   = 1'b1;
                        we_d    = 1'b0;
                        sel_d   = BusSelAll;
                        addr_d  = if_addr_i;
                        wdata_d = '0;
                    end
                end
            end
            BusBusyIf, BusBusyMem: begin
                if (state_q == BusBusyIf && flush_i) annul_d = 1'b1;
                // Ack on the last timeout cycle still counts as a normal completion.
                if (bus_ack_i || cnt_q == TimeoutLast) begin
                    state_d = BusIdle;
                    cnt_d   = '0;
                    cyc_d   = 1'b0;
                    err_d   = !bus_ack_i;
                    if (state_q == BusBusyIf) begin
                        if_ready_d = !(annul_q || flush_i);
                        if_data_d  = (bus_ack_i && if_ready_d) ? bus_data_i : '0;
                    end else begin
                        mem_ready_d = 1'b1;
                        mem_data_d  = (bus_ack_i && !we_q) ? bus_data_i : '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = BusIdle;
        endcase
    end

    assign bus_cyc_o      = cyc_q;
    assign bus_stb_o      = cyc_q;
    assign bus_we_o       = we_q;
    assign bus_sel_o      = sel_q;
    assign bus_addr_o     = addr_q;
    assign bus_data_o     = wdata_q;
    assign bus_err_o      = err_q;
    assign if_ready_o     = if_ready_q;
    assign if_data_o      = if_data_q;
    assign mem_ready_o    = mem_ready_q;
    assign mem_data_o     = mem_data_q;
    assign stallreq_if_o  = if_req_i & ~if_ready_q;
    assign stallreq_mem_o = mem_req_i & ~mem_ready_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: scoreboard of expected completions, immediate-assertion checks.
module tb_bus_arbiter;

    typedef struct packed {
        logic        is_mem;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_ready_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_data_i;
    logic [31:0] mem_data_o;
    logic        mem_ready_o;
    logic        flush_i;
    logic        stallreq_if_o;
    logic        stallreq_mem_o;
    logic        bus_cyc_o;
    logic        bus_stb_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_data_o;
    logic [31:0] bus_data_i;
    logic        bus_ack_i;
    logic        bus_err_o;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .if_req_i       (if_req_i),
        .if_addr_i      (if_addr_i),
        .if_data_o      (if_data_o),
        .if_ready_o     (if_ready_o),
        .mem_req_i      (mem_req_i),
        .mem_we_i       (mem_we_i),
        .mem_sel_i      (mem_sel_i),
        .mem_addr_i     (mem_addr_i),
        .mem_data_i     (mem_data_i),
        .mem_data_o     (mem_data_o),
        .mem_ready_o    (mem_ready_o),
        .flush_i        (flush_i),
        .stallreq_if_o  (stallreq_if_o),
        .stallreq_mem_o (stallreq_mem_o),
        .bus_cyc_o      (bus_cyc_o),
        .bus_stb_o      (bus_stb_o),
        .bus_we_o       (bus_we_o),
        .bus_sel_o      (bus_sel_o),
        .bus_addr_o     (bus_addr_o),
        .bus_data_o     (bus_data_o),
        .bus_data_i     (bus_data_i),
        .bus_ack_i      (bus_ack_i),
        .bus_err_o      (bus_err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic await_ready(input string tag, input int budget);
        bit   got = 1'b0;
        exp_t e;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            got = if_ready_o | mem_ready_o;
        end
        check_b({tag, "_ready_seen"}, got, 1'b1);
        if (got) begin
            check_b({tag, "_sb_pending"}, sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_b({tag, "_mem_ready"}, mem_ready_o, e.is_mem);
                check_b({tag, "_if_ready"}, if_ready_o, !e.is_mem);
                check_w({tag, "_data"}, e.is_mem ? mem_data_o : if_data_o, e.data);
                check_b({tag, "_bus_err"}, bus_err_o, e.err);
                check_b({tag, "_cyc_dropped"}, bus_cyc_o, 1'b0);
            end
        end
    endtask

    initial begin
        rst = 1'b0; if_req_i = 1'b0; if_addr_i = '0; mem_req_i = 1'b0; mem_we_i = 1'b0;
        mem_sel_i = '0; mem_addr_i = '0; mem_data_i = '0; flush_i = 1'b0;
        bus_data_i = '0; bus_ack_i = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_b("rst_cyc", bus_cyc_o, 1'b0);
        check_b("rst_stb", bus_stb_o, 1'b0);
        check_w("rst_sel", 32'(bus_sel_o), 32'h0);
        check_w("rst_addr", bus_addr_o, 32'h0);
        check_b("rst_if_ready", if_ready_o, 1'b0);
        check_b("rst_mem_ready", mem_ready_o, 1'b0);
        check_b("rst_err", bus_err_o, 1'b0);
        rst = 1'b1;

        // IF only
        @(negedge clk);
        if_req_i = 1'b1; if_addr_i = 32'h0000_0100;
        sb.push_back('{is_mem: 1'b0, data: 32'h3C01_1234, err: 1'b0});
        #1 check_b("if1_stall_pending", stallreq_if_o, 1'b1);
        @(negedge clk);
        check_b("if1_cyc", bus_cyc_o, 1'b1);
        check_b("if1_stb", bus_stb_o, 1'b1);
        check_b("if1_we", bus_we_o, 1'b0);
        check_w("if1_sel", 32'(bus_sel_o), 32'hF);
        check_w("if1_addr", bus_addr_o, 32'h100);
        @(negedge clk);
        check_b("if1_wait_cyc", bus_cyc_o, 1'b1);
        bus_ack_i = 1'b1; bus_data_i = 32'h3C01_1234;
        await_ready("if1", 3);
        check_b("if1_stall_done", stallreq_if_o, 1'b0);
        bus_ack_i = 1'b0; if_req_i = 1'b0;
        @(negedge clk);
        check_b("if1_ready_one_cycle", if_ready_o, 1'b0);

        // Simultaneous store + fetch: MEM first
        @(negedge clk);
        if_req_i = 1'b1; if_addr_i = 32'h0000_0200;
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h80;
        mem_data_i = 32'hDEAD_BEEF; mem_sel_i = 4'b0011;
        sb.push_back('{is_mem: 1'b1, data: 32'h0, err: 1'b0});
        sb.push_back('{is_mem: 1'b0, data: 32'h1234_5678, err: 1'b0});
        @(negedge clk);
        check_b("sim_st_we", bus_we_o, 1'b1);
        check_w("sim_st_sel", 32'(bus_sel_o), 32'h3);
        check_w("sim_st_addr", bus_addr_o, 32'h80);
        check_w("sim_st_wdata", bus_data_o, 32'hDEAD_BEEF);
        check_b("sim_stall_mem", stallreq_mem_o, 1'b1);
        bus_ack_i = 1'b1; bus_data_i = 32'h9999_9999;
        await_ready("sim_st", 3);
        bus_ack_i = 1'b0; mem_req_i = 1'b0;
        #1 check_b("sim_stall_if_a", stallreq_if_o, 1'b1);
        @(negedge clk);
        check_b("sim_gap_cyc", bus_cyc_o, 1'b0);
        check_b("sim_stall_if_b", stallreq_if_o, 1'b1);
        @(negedge clk);
        check_b("sim_if_cyc", bus_cyc_o, 1'b1);
        check_b("sim_if_we", bus_we_o, 1'b0);
        check_w("sim_if_addr", bus_addr_o, 32'h200);
        bus_ack_i = 1'b1; bus_data_i = 32'h1234_5678;
        await_ready("sim_if", 3);
        check_b("sim_stall_if_done", stallreq_if_o, 1'b0);
        bus_ack_i = 1'b0; if_req_i = 1'b0;

        // Flush during BUSY_IF
        @(negedge clk);
        if_req_i = 1'b1; if_addr_i = 32'h0000_0300;
        @(negedge clk);
        check_b("fl_cyc0", bus_cyc_o, 1'b1);
        flush_i = 1'b1; if_req_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            flush_i = 1'b0;
            check_b("fl_cyc_hold", bus_cyc_o, 1'b1);
            check_b("fl_no_ready", if_ready_o, 1'b0);
        end
        @(negedge clk);
        check_b("fl_cyc_last", bus_cyc_o, 1'b1);
        bus_ack_i = 1'b1; bus_data_i = 32'h7777_7777;
        @(negedge clk);
        check_b("fl_done_cyc", bus_cyc_o, 1'b0);
        check_b("fl_annulled", if_ready_o, 1'b0);
        check_b("fl_no_err", bus_err_o, 1'b0);
        bus_ack_i = 1'b0;
        if_req_i = 1'b1; if_addr_i = 32'h0000_0400;
        sb.push_back('{is_mem: 1'b0, data: 32'hCAFE_0001, err: 1'b0});
        @(negedge clk);
        check_b("fl_next_cyc", bus_cyc_o, 1'b1);
        check_w("fl_next_addr", bus_addr_o, 32'h400);
        bus_ack_i = 1'b1; bus_data_i = 32'hCAFE_0001;
        await_ready("fl_next", 3);
        bus_ack_i = 1'b0; if_req_i = 1'b0;

        // Timeout on a load
        @(negedge clk);
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h84;
        bus_data_i = 32'h5555_AAAA;
        sb.push_back('{is_mem: 1'b1, data: 32'h0, err: 1'b1});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_b("to_cyc_busy", bus_cyc_o, 1'b1);
            check_b("to_no_err_yet", bus_err_o, 1'b0);
        end
        await_ready("to", 1);
        mem_req_i = 1'b0;
        @(negedge clk);
        check_b("to_err_one_cycle", bus_err_o, 1'b0);

        // Ack on the timeout cycle wins
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h88;
        sb.push_back('{is_mem: 1'b1, data: 32'h0BAD_F00D, err: 1'b0});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_b("ackto_cyc_busy", bus_cyc_o, 1'b1);
        end
        @(negedge clk);
        check_b("ackto_cyc_last", bus_cyc_o, 1'b1);
        bus_ack_i = 1'b1; bus_data_i = 32'h0BAD_F00D;
        await_ready("ackto", 1);
        bus_ack_i = 1'b0; mem_req_i = 1'b0;

        // Ack while idle is ignored
        @(negedge clk);
        bus_ack_i = 1'b1; bus_data_i = 32'hFFFF_FFFF;
        @(negedge clk);
        check_b("idle_ack_if", if_ready_o, 1'b0);
        check_b("idle_ack_mem", mem_ready_o, 1'b0);
        check_b("idle_ack_cyc", bus_cyc_o, 1'b0);
        bus_ack_i = 1'b0;

        // Async reset during BUSY_MEM
        @(negedge clk);
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'hC;
        mem_addr_i = 32'h90; mem_data_i = 32'h1111_2222;
        @(negedge clk);
        check_b("ar_cyc_before", bus_cyc_o, 1'b1);
        #2 rst = 1'b0; mem_req_i = 1'b0;
        #1;
        check_b("ar_cyc", bus_cyc_o, 1'b0);
        check_b("ar_stb", bus_stb_o, 1'b0);
        check_b("ar_we", bus_we_o, 1'b0);
        check_w("ar_sel", 32'(bus_sel_o), 32'h0);
        check_w("ar_addr", bus_addr_o, 32'h0);
        check_w("ar_wdata", bus_data_o, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_b("ar_idle_cyc", bus_cyc_o, 1'b0);
        if_req_i = 1'b1; if_addr_i = 32'h0000_0500;
        sb.push_back('{is_mem: 1'b0, data: 32'h600D_0001, err: 1'b0});
        @(negedge clk);
        check_b("ar_post_cyc", bus_cyc_o, 1'b1);
        check_w("ar_post_addr", bus_addr_o, 32'h500);
        bus_ack_i = 1'b1; bus_data_i = 32'h600D_0001;
        await_ready("ar_post", 3);
        bus_ack_i = 1'b0; if_req_i = 1'b0;

        check_w("sb_drained", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
